// File: rtl/tdm_demux.sv
// Registered N-channel TDM demultiplexer: locks to frame_sync, tracks the slot
// index and fans the muxed word stream out onto per-channel registered outputs.
module tdm_demux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic [SLOT_W-1:0]          slot, slot_nxt;
  logic [NUM_CH*DATA_W-1:0]   ch_data_nxt;
  logic [NUM_CH-1:0]          ch_valid_nxt;
  logic                       frame_done_nxt;
  logic                       sync_err_nxt;
  logic                       wr;
  logic [SLOT_W-1:0]          wr_slot;
  logic                       beat;

  assign beat = en & din_valid;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      ch_data    <= ch_data_nxt;
      ch_valid   <= ch_valid_nxt;
      frame_done <= frame_done_nxt;
      locked     <= (state_nxt == LOCKED);
      sync_err   <= sync_err_nxt;
    end
  end

  // Next-state, slot tracking and write decision.
  always_comb begin
    state_nxt      = state;
    slot_nxt       = slot;
    frame_done_nxt = 1'b0;
    sync_err_nxt   = 1'b0;
    wr             = 1'b0;
    wr_slot        = '0;

    if (beat) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            wr        = 1'b1;
            slot_nxt  = SLOT_W'(1);
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // Early sync restarts the frame at slot 0; the partial frame is abandoned.
            wr           = 1'b1;
            slot_nxt     = SLOT_W'(1);
            sync_err_nxt = (slot != '0);
          end else if (slot == '0) begin
            sync_err_nxt = 1'b1;
            slot_nxt     = '0;
            state_nxt    = HUNT;
          end else begin
            wr             = 1'b1;
            wr_slot        = slot;
            frame_done_nxt = (slot == LAST_SLOT);
            slot_nxt       = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
          end
        end
        default: begin
          state_nxt = HUNT;
          slot_nxt  = '0;
        end
      endcase
    end
  end

  // Channel fan-out: one slice and one valid bit for the written slot.
  always_comb begin
    ch_data_nxt  = ch_data;
    ch_valid_nxt = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (wr && (wr_slot == SLOT_W'(k))) begin
        ch_data_nxt[k*DATA_W +: DATA_W] = din;
        ch_valid_nxt[k]                 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Table-driven directed bench for tdm_demux (NUM_CH=4, DATA_W=8).
module tb_tdm_demux;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NROWS  = 29;

  logic                     clk;
  logic                     rst_n;
  logic                     en;
  logic [DATA_W-1:0]        din;
  logic                     din_valid;
  logic                     frame_sync;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     frame_done;
  logic                     locked;
  logic                     sync_err;

  typedef struct {
    logic        en;
    logic        dv;
    logic        fs;
    logic [7:0]  din;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic        efd;
    logic        elk;
    logic        eerr;
  } vec_t;

  vec_t tbl [NROWS];
  int   tests;
  int   failed;

  tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t row(logic e, logic dv, logic fs, logic [7:0] d,
                               logic [3:0] ev, logic [31:0] ed,
                               logic efd, logic elk, logic eerr);
    vec_t r;
    r.en = e; r.dv = dv; r.fs = fs; r.din = d;
    r.ev = ev; r.ed = ed; r.efd = efd; r.elk = elk; r.eerr = eerr;
    return r;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input vec_t v);
    check("ch_valid",   idx, 32'(ch_valid),   32'(v.ev));
    check("ch_data",    idx, ch_data,         v.ed);
    check("frame_done", idx, 32'(frame_done), 32'(v.efd));
    check("locked",     idx, 32'(locked),     32'(v.elk));
    check("sync_err",   idx, 32'(sync_err),   32'(v.eerr));
  endtask

  // Drive one cycle of inputs at the falling edge and check just after the rising edge.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    en         = v.en;
    din_valid  = v.dv;
    frame_sync = v.fs;
    din        = v.din;
    @(posedge clk);
    #1;
    check_outs(idx, v);
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    // Basic frame, then missing sync at slot 0.
    tbl[0]  = row(1, 1, 1, 8'h11, 4'b0001, 32'h0000_0011, 0, 1, 0);
    tbl[1]  = row(1, 1, 0, 8'h22, 4'b0010, 32'h0000_2211, 0, 1, 0);
    tbl[2]  = row(1, 1, 0, 8'h33, 4'b0100, 32'h0033_2211, 0, 1, 0);
    tbl[3]  = row(1, 1, 0, 8'h44, 4'b1000, 32'h4433_2211, 1, 1, 0);
    tbl[4]  = row(1, 1, 0, 8'h55, 4'b0000, 32'h4433_2211, 0, 0, 1);
    // Hunt drops unsynced beats, then relocks.
    tbl[5]  = row(1, 1, 0, 8'hAA, 4'b0000, 32'h4433_2211, 0, 0, 0);
    tbl[6]  = row(1, 1, 0, 8'hBB, 4'b0000, 32'h4433_2211, 0, 0, 0);
    tbl[7]  = row(1, 1, 1, 8'h01, 4'b0001, 32'h4433_2201, 0, 1, 0);
    tbl[8]  = row(1, 1, 0, 8'h02, 4'b0010, 32'h4433_0201, 0, 1, 0);
    tbl[9]  = row(1, 1, 0, 8'h03, 4'b0100, 32'h4403_0201, 0, 1, 0);
    tbl[10] = row(1, 1, 0, 8'h04, 4'b1000, 32'h0403_0201, 1, 1, 0);
    // Early sync at slot 2 restarts the frame.
    tbl[11] = row(1, 1, 1, 8'h10, 4'b0001, 32'h0403_0210, 0, 1, 0);
    tbl[12] = row(1, 1, 0, 8'h20, 4'b0010, 32'h0403_2010, 0, 1, 0);
    tbl[13] = row(1, 1, 1, 8'h30, 4'b0001, 32'h0403_2030, 0, 1, 1);
    tbl[14] = row(1, 1, 0, 8'h40, 4'b0010, 32'h0403_4030, 0, 1, 0);
    tbl[15] = row(1, 1, 0, 8'h50, 4'b0100, 32'h0450_4030, 0, 1, 0);
    tbl[16] = row(1, 1, 0, 8'h60, 4'b1000, 32'h6050_4030, 1, 1, 0);
    // Frame with valid gaps and an enable freeze after slot 1.
    tbl[17] = row(1, 1, 1, 8'h71, 4'b0001, 32'h6050_4071, 0, 1, 0);
    tbl[18] = row(1, 0, 0, 8'hFF, 4'b0000, 32'h6050_4071, 0, 1, 0);
    tbl[19] = row(1, 0, 1, 8'hFF, 4'b0000, 32'h6050_4071, 0, 1, 0);
    tbl[20] = row(1, 1, 0, 8'h72, 4'b0010, 32'h6050_7271, 0, 1, 0);
    tbl[21] = row(0, 1, 0, 8'hEE, 4'b0000, 32'h6050_7271, 0, 1, 0);
    tbl[22] = row(0, 1, 1, 8'hEE, 4'b0000, 32'h6050_7271, 0, 1, 0);
    tbl[23] = row(0, 1, 0, 8'hEE, 4'b0000, 32'h6050_7271, 0, 1, 0);
    tbl[24] = row(1, 0, 0, 8'hEE, 4'b0000, 32'h6050_7271, 0, 1, 0);
    tbl[25] = row(1, 1, 0, 8'h73, 4'b0100, 32'h6073_7271, 0, 1, 0);
    tbl[26] = row(1, 0, 0, 8'hFF, 4'b0000, 32'h6073_7271, 0, 1, 0);
    tbl[27] = row(1, 0, 0, 8'hFF, 4'b0000, 32'h6073_7271, 0, 1, 0);
    tbl[28] = row(1, 1, 0, 8'h74, 4'b1000, 32'h7473_7271, 1, 1, 0);

    rst_n      = 1'b0;
    en         = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs(-1, row(0, 0, 0, 8'h00, 4'b0000, 32'h0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NROWS); i++) apply(i, tbl[i]);

    // Async reset mid-frame: outputs clear before the next clock edge.
    apply(100, row(1, 1, 1, 8'h81, 4'b0001, 32'h7473_7281, 0, 1, 0));
    apply(101, row(1, 1, 0, 8'h82, 4'b0010, 32'h7473_8281, 0, 1, 0));
    apply(102, row(1, 1, 0, 8'h83, 4'b0100, 32'h7483_8281, 0, 1, 0));
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs(103, row(0, 0, 0, 8'h00, 4'b0000, 32'h0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(104, row(1, 1, 0, 8'h84, 4'b0000, 32'h0000_0000, 0, 0, 0));
    apply(105, row(1, 1, 1, 8'hA1, 4'b0001, 32'h0000_00A1, 0, 1, 0));
    apply(106, row(1, 1, 0, 8'hA2, 4'b0010, 32'h0000_A2A1, 0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
